instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction memory.
- Owns the 64-bit program counter and drives it as Inst_Address to the byte-addressed, little-endian instruction memory.
- Captures the returned 32-bit Instruction into the IF/ID pipeline register, with stall, branch-redirect flush, halt and fault handling.
- The decode stage consumes the IF/ID outputs.

---
 rtl/instruction_fetch_unit.sv | 118 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Fetch stage in front of a byte-addressed, little-endian instruction memory.
// Holds the 64-bit program counter, presents it as Inst_Address, and captures
// the combinationally returned Instruction into the IF/ID register. It handles
// decode stalls, branch redirects (with a flush), end-of-program halt and
// illegal-address faults.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   Stall            hold PC and IF/ID (hazard from decode)
//   Branch_Taken     redirect request from execute
//   Branch_Target    redirect address, valid with Branch_Taken
//   Instruction      memory read data for Inst_Address (same cycle)
//   Inst_Address     fetch address, equal to the PC register
//   IFID_PC          PC of the captured instruction
//   IFID_Instruction captured instruction (NOP_INST when a bubble)
//   IFID_Valid       IF/ID holds a real instruction
//   Halted           sticky: fetch stopped until reset
//   Fault            sticky: the halt came from an illegal fetch address
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_BYTES = 16,
  parameter logic [31:0] NOP_INST  = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  input  logic [31:0] Instruction,
  output logic [63:0] Inst_Address,
  output logic [63:0] IFID_PC,
  output logic [31:0] IFID_Instruction,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic        Fault
);

  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 4);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state;
  logic [63:0] pc_p0;
  logic [63:0] ifid_pc_p1;
  logic [31:0] ifid_inst_p1;
  logic        vld_p1;
  logic        halted_q;
  logic        fault_q;

  // A redirect target must be word aligned and inside the memory.
  function automatic logic target_illegal(input logic [63:0] addr);
    return (addr[1:0] != 2'b00) || (addr > LAST_ADDR);
  endfunction

  // Stage p0: PC drives the memory address directly.
  assign Inst_Address = pc_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      pc_p0        <= RESET_PC;
      ifid_pc_p1   <= 64'h0;
      ifid_inst_p1 <= NOP_INST;
      vld_p1       <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (Branch_Taken) begin
            // Redirect always flushes the instruction fetched on the wrong path.
            ifid_inst_p1 <= NOP_INST;
            vld_p1       <= 1'b0;
            if (target_illegal(Branch_Target)) begin
              fault_q  <= 1'b1;
              halted_q <= 1'b1;
              state    <= HALT;
            end else begin
              pc_p0 <= Branch_Target;
            end
          end else if (Stall) begin
            // Everything holds.
          end else if (pc_p0 > LAST_ADDR) begin
            ifid_inst_p1 <= NOP_INST;
            vld_p1       <= 1'b0;
            fault_q      <= 1'b1;
            halted_q     <= 1'b1;
            state        <= HALT;
          end else if (Instruction == 32'h0) begin
            // Unprogrammed memory marks the end of the program: clean halt.
            ifid_inst_p1 <= NOP_INST;
            vld_p1       <= 1'b0;
            halted_q     <= 1'b1;
            state        <= HALT;
          end else begin
            // Stage p1: capture into IF/ID and advance.
            ifid_pc_p1   <= pc_p0;
            ifid_inst_p1 <= Instruction;
            vld_p1       <= 1'b1;
            pc_p0        <= pc_p0 + 64'd4;
          end
        end
        HALT: state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

  assign IFID_PC          = ifid_pc_p1;
  assign IFID_Instruction = ifid_inst_p1;
  assign IFID_Valid       = vld_p1;
  assign Halted           = halted_q;
  assign Fault            = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam int          MEM_BYTES = 16;
  localparam logic [31:0] NOP       = 32'h00000013;
  localparam logic [63:0] LAST      = 64'(MEM_BYTES - 4);

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall = 1'b0;
  logic        Branch_Taken = 1'b0;
  logic [63:0] Branch_Target = 64'h0;
  logic [31:0] Instruction;
  logic [63:0] Inst_Address;
  logic [63:0] IFID_PC;
  logic [31:0] IFID_Instruction;
  logic        IFID_Valid;
  logic        Halted;
  logic        Fault;

  int n_cmp = 0;
  int n_bad = 0;
  logic started = 1'b0;

  logic [7:0] mem [0:MEM_BYTES-1];

  instruction_fetch_unit #(
    .RESET_PC (64'h0),
    .MEM_BYTES(MEM_BYTES),
    .NOP_INST (NOP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .Stall           (Stall),
    .Branch_Taken    (Branch_Taken),
    .Branch_Target   (Branch_Target),
    .Instruction     (Instruction),
    .Inst_Address    (Inst_Address),
    .IFID_PC         (IFID_PC),
    .IFID_Instruction(IFID_Instruction),
    .IFID_Valid      (IFID_Valid),
    .Halted          (Halted),
    .Fault           (Fault)
  );

  always #5 clk = ~clk;

  // Little-endian combinational memory; reads outside the array return 0.
  always_comb begin
    Instruction = 32'h0;
    if (Inst_Address <= LAST && Inst_Address[1:0] == 2'b00)
      Instruction = {mem[4'(Inst_Address[3:0] + 4'd3)], mem[4'(Inst_Address[3:0] + 4'd2)],
                     mem[4'(Inst_Address[3:0] + 4'd1)], mem[Inst_Address[3:0]]};
  end

  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [31:0] w;
    w = 32'h0;
    if (a <= LAST && a % 4 == 0)
      for (int b = 0; b < 4; b++) w[8*b +: 8] = mem[int'(a) + b];
    return w;
  endfunction

  task automatic put_word(input int a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) mem[a + b] = w[8*b +: 8];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of fetch: what the outputs must be after each edge.
  logic [63:0] m_pc = 64'h0, m_ifid_pc = 64'h0;
  logic [31:0] m_inst = NOP;
  logic m_valid = 1'b0, m_halted = 1'b0, m_fault = 1'b0, m_boot = 1'b1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 64'h0; m_ifid_pc = 64'h0; m_inst = NOP;
      m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halted) begin
      if (Branch_Taken) begin
        m_valid = 1'b0; m_inst = NOP;
        if (Branch_Target % 4 != 0 || Branch_Target > LAST) begin
          m_fault = 1'b1; m_halted = 1'b1;
        end else m_pc = Branch_Target;
      end else if (!Stall) begin
        if (m_pc > LAST) begin
          m_fault = 1'b1; m_halted = 1'b1; m_valid = 1'b0; m_inst = NOP;
        end else if (word_at(m_pc) == 32'h0) begin
          m_halted = 1'b1; m_valid = 1'b0; m_inst = NOP;
        end else begin
          m_ifid_pc = m_pc; m_inst = word_at(m_pc); m_valid = 1'b1; m_pc = m_pc + 4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_addr",   Inst_Address,     m_pc);
      check("model_ifidpc", IFID_PC,          m_ifid_pc);
      check("model_inst",   IFID_Instruction, m_inst);
      check("model_valid",  IFID_Valid,       m_valid);
      check("model_halted", Halted,           m_halted);
      check("model_fault",  Fault,            m_fault);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; reset pulse stays between edges.
  task automatic do_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h0;
    put_word(0, 32'h02853483);
    put_word(4, 32'h008A8433);
    reset = 1'b0;
    #12;
    check("rst_addr",  Inst_Address, 64'h0);
    check("rst_pc",    IFID_PC, 64'h0);
    check("rst_inst",  IFID_Instruction, NOP);
    check("rst_valid", IFID_Valid, 1'b0);
    check("rst_halt",  Halted, 1'b0);
    check("rst_fault", Fault, 1'b0);
    reset = 1'b1;
    started = 1'b1;

    // Sequential fetch to end of program.
    tick(); check("boot_valid", IFID_Valid, 1'b0); check("boot_addr", Inst_Address, 64'h0);
    tick(); check("f0_pc", IFID_PC, 64'h0); check("f0_inst", IFID_Instruction, 32'h02853483);
    check("f0_valid", IFID_Valid, 1'b1); check("f0_addr", Inst_Address, 64'h4);
    tick(); check("f1_pc", IFID_PC, 64'h4); check("f1_inst", IFID_Instruction, 32'h008A8433);
    tick(); check("end_halt", Halted, 1'b1); check("end_fault", Fault, 1'b0);
    check("end_valid", IFID_Valid, 1'b0); check("end_inst", IFID_Instruction, NOP);
    check("end_addr", Inst_Address, 64'h8);
    tick(); tick(); check("end_hold_addr", Inst_Address, 64'h8);

    // Stall holds everything for three cycles.
    do_reset(); tick(); tick();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", Inst_Address, 64'h4);
      check("stall_pc", IFID_PC, 64'h0);
      check("stall_inst", IFID_Instruction, 32'h02853483);
    end
    Stall = 1'b0;
    tick(); check("unstall_inst", IFID_Instruction, 32'h008A8433); check("unstall_pc", IFID_PC, 64'h4);

    // Branch wins over stall.
    do_reset(); tick(); tick();
    Branch_Taken = 1'b1; Branch_Target = 64'h0; Stall = 1'b1;
    tick(); check("br_addr", Inst_Address, 64'h0); check("br_valid", IFID_Valid, 1'b0);
    check("br_inst", IFID_Instruction, NOP);
    Branch_Taken = 1'b0; Stall = 1'b0;
    tick(); check("br_cap_inst", IFID_Instruction, 32'h02853483); check("br_cap_pc", IFID_PC, 64'h0);
    check("br_cap_valid", IFID_Valid, 1'b1);

    // Misaligned redirect.
    do_reset(); tick(); tick();
    Branch_Taken = 1'b1; Branch_Target = 64'h6;
    tick(); check("mis_fault", Fault, 1'b1); check("mis_halt", Halted, 1'b1);
    check("mis_addr", Inst_Address, 64'h4);
    Branch_Target = 64'h0;
    tick(); tick(); check("mis_hold_addr", Inst_Address, 64'h4);
    Branch_Taken = 1'b0;

    // Out-of-range redirect.
    do_reset(); tick();
    Branch_Taken = 1'b1; Branch_Target = 64'h40;
    tick(); check("oor_fault", Fault, 1'b1); check("oor_halt", Halted, 1'b1);
    Branch_Target = 64'h8;
    tick(); check("oor_hold_addr", Inst_Address, 64'h0);
    Branch_Taken = 1'b0;

    // Last legal word fetched, then running off the end faults.
    put_word(12, 32'h00000093);
    do_reset(); tick();
    Branch_Taken = 1'b1; Branch_Target = 64'hC;
    tick(); Branch_Taken = 1'b0;
    check("last_addr", Inst_Address, 64'hC);
    tick(); check("last_inst", IFID_Instruction, 32'h00000093); check("last_pc", IFID_PC, 64'hC);
    tick(); check("off_fault", Fault, 1'b1); check("off_halt", Halted, 1'b1);
    check("off_addr", Inst_Address, 64'h10);
    put_word(12, 32'h0);

    // Asynchronous reset between edges.
    do_reset(); tick(); tick();
    #2; reset = 1'b0; #1;
    check("mid_addr", Inst_Address, 64'h0); check("mid_valid", IFID_Valid, 1'b0);
    check("mid_inst", IFID_Instruction, NOP); check("mid_halt", Halted, 1'b0);
    check("mid_fault", Fault, 1'b0);
    #2; reset = 1'b1;
    tick(); check("mid_boot_valid", IFID_Valid, 1'b0);
    tick(); check("mid_cap_valid", IFID_Valid, 1'b1); check("mid_cap_inst", IFID_Instruction, 32'h02853483);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
